// File: rtl/temp_scan_pkg.sv
// Shared types and widths for the temperature scan controller.
package temp_scan_pkg;

  localparam int unsigned TEMP_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TO_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    EVAL,
    NEXT
  } state_e;

endpackage

// File: rtl/temperature_scan_controller_if.sv
// Sensor-side req/ack sample bus. The controller is the master, the sensor mux the slave.
interface temperature_scan_controller_if
  import temp_scan_pkg::*;
#(
  parameter int unsigned NUM_SENSORS = 4
);
  localparam int unsigned SEL_W = $clog2(NUM_SENSORS);

  logic              sampleReq;
  logic [SEL_W-1:0]  sampleSel;
  logic              sampleAck;
  logic [TEMP_W-1:0] sampleData;

  modport master (
    output sampleReq,
    output sampleSel,
    input  sampleAck,
    input  sampleData
  );

  modport slave (
    input  sampleReq,
    input  sampleSel,
    output sampleAck,
    output sampleData
  );
endinterface

// File: rtl/temp_channel_tracker.sv
// Per-sensor state: saturating abnormal-sample count, debounced alarm and timeout fault.
// Optional LATCH_ALARM_EN makes the alarm sticky until alarm_clear_i.
module temp_channel_tracker
  import temp_scan_pkg::*;
#(
  parameter int unsigned ALARM_COUNT = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic update_i,       // end of EVAL for this channel
  input  logic abnormal_i,     // analyzer verdict, valid with update_i
  input  logic timeout_i,      // REQ expired without ack
  input  logic ack_ok_i,       // sensor answered
  input  logic alarm_clear_i,
  output logic alarm_o,
  output logic fault_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(ALARM_COUNT);

  logic [CNT_W-1:0] count_q, count_d;
  logic             fault_q, fault_d;

  // Count and fault next-state; a timeout leaves the count untouched.
  always_comb begin
    count_d = count_q;
    fault_d = fault_q;
    if (update_i) begin
      if (abnormal_i) begin
        count_d = (count_q == CntMax) ? count_q : count_q + CNT_W'(1);
      end else begin
        count_d = '0;
      end
    end
    if (ack_ok_i) begin
      fault_d = 1'b0;
    end else if (timeout_i) begin
      fault_d = 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  assign fault_o = fault_q;

`ifdef LATCH_ALARM_EN
  logic alarm_q, alarm_d;

  // Sticky alarm: a setting update beats a simultaneous clear.
  always_comb begin
    alarm_d = alarm_q;
    if (update_i && abnormal_i && (count_d == CntMax)) begin
      alarm_d = 1'b1;
    end else if (alarm_clear_i && (count_q < CntMax)) begin
      alarm_d = 1'b0;
    end
  end

  // Latched alarm register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm_o = alarm_q;
`else
  logic unused_alarm_clear;
  assign unused_alarm_clear = alarm_clear_i;
  assign alarm_o = (count_q == CntMax);
`endif

endmodule

// File: rtl/temperature_scan_controller.sv
// Round-robin scheduler sharing one temperature analyzer between NUM_SENSORS sensors.
// Optional macro LATCH_ALARM_EN: sticky alarms cleared by alarmClear.
module temperature_scan_controller
  import temp_scan_pkg::*;
#(
  parameter int unsigned NUM_SENSORS    = 4,
  parameter int unsigned ALARM_COUNT    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                                 clk,
  input  logic                                 resetN,
  input  logic                                 enable,
  temperature_scan_controller_if.master        sensor_bus,
  output logic [TEMP_W-1:0]                    analyzerTemperature,
  input  logic                                 analyzerAbnormality,
  input  logic                                 alarmClear,
  output logic [NUM_SENSORS-1:0]               alarm,
  output logic [NUM_SENSORS-1:0]               sensorFault,
  output logic                                 scanDone
);

  localparam int unsigned     SEL_W   = $clog2(NUM_SENSORS);
  localparam logic [SEL_W-1:0] IdxLast = SEL_W'(NUM_SENSORS - 1);
  localparam logic [TO_W-1:0]  ToLast  = TO_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic              update, timeout, ack_ok, scan_done, req;

  // Scan FSM: next state, strobes and outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    to_cnt_d  = to_cnt_q;
    temp_d    = temp_q;
    update    = 1'b0;
    timeout   = 1'b0;
    ack_ok    = 1'b0;
    scan_done = 1'b0;
    req       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        // Ack on the final timeout cycle still counts as a valid sample.
        if (sensor_bus.sampleAck) begin
          temp_d   = sensor_bus.sampleData;
          ack_ok   = 1'b1;
          to_cnt_d = '0;
          state_d  = EVAL;
        end else if (to_cnt_q == ToLast) begin
          timeout  = 1'b1;
          to_cnt_d = '0;
          state_d  = NEXT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      EVAL: begin
        update  = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == IdxLast) begin
          idx_d     = '0;
          scan_done = 1'b1;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
        state_d = enable ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      to_cnt_q <= '0;
      temp_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      temp_q   <= temp_d;
    end
  end

  assign sensor_bus.sampleReq = req;
  assign sensor_bus.sampleSel = idx_q;
  assign analyzerTemperature  = temp_q;
  assign scanDone             = scan_done;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
    logic sel;
    assign sel = (idx_q == SEL_W'(i));

    temp_channel_tracker #(
      .ALARM_COUNT (ALARM_COUNT)
    ) u_tracker (
      .clk_i         (clk),
      .rst_ni        (resetN),
      .update_i      (update && sel),
      .abnormal_i    (analyzerAbnormality),
      .timeout_i     (timeout && sel),
      .ack_ok_i      (ack_ok && sel),
      .alarm_clear_i (alarmClear),
      .alarm_o       (alarm[i]),
      .fault_o       (sensorFault[i])
    );
  end

endmodule

// File: tb/tb_temperature_scan_controller.sv
// Self-checking bench for temperature_scan_controller: directed phases plus randomized
// rounds checked against a per-visit transaction model.
module tb_temperature_scan_controller;

  localparam int unsigned N     = 4;
  localparam int unsigned ALARM = 3;
  localparam int unsigned TMO   = 16;
  localparam int unsigned SEL_W = $clog2(N);
  localparam int          NEVER = 255;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         enable = 1'b0;
  logic         alarmClear = 1'b0;
  logic [7:0]   analyzer_temp;
  logic         analyzer_abn;
  logic [N-1:0] alarm;
  logic [N-1:0] sensor_fault;
  logic         scan_done;

  int n_checks = 0;
  int n_errors = 0;

  // Sensor behaviour: ack latency in REQ cycles (NEVER = silent) and returned value.
  int         sens_lat[N];
  logic [7:0] sens_val[N];
  bit         rand_clear = 1'b0;

  // Reference model state.
  int m_idx;
  int m_cnt[N];
  bit m_flt[N];
  bit m_alm[N];

  temperature_scan_controller_if #(.NUM_SENSORS(N)) bus ();

  always #5 clk = ~clk;

  // Stand-in TemperatureAnalyzer: normal band is 35..38 inclusive.
  function automatic logic abn_f(input logic [7:0] t);
    return (t < 8'd35) || (t > 8'd38);
  endfunction

  assign analyzer_abn = abn_f(analyzer_temp);

  temperature_scan_controller #(
    .NUM_SENSORS    (N),
    .ALARM_COUNT    (ALARM),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .enable              (enable),
    .sensor_bus          (bus),
    .analyzerTemperature (analyzer_temp),
    .analyzerAbnormality (analyzer_abn),
    .alarmClear          (alarmClear),
    .alarm               (alarm),
    .sensorFault         (sensor_fault),
    .scanDone            (scan_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_alarm();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_alm[i];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_fault();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_flt[i];
    return v;
  endfunction

  function automatic void model_reset();
    m_idx = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_flt[i] = 1'b0;
      m_alm[i] = 1'b0;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One sensor visit: starts at a negedge in NEXT/IDLE, ends at the negedge of NEXT.
  task automatic visit(input bit drop_en);
    int         gap, nreq, lat, exp_req, i;
    bit         exp_ack, sel_ok;
    logic [7:0] val;
    logic [SEL_W-1:0] exp_sel;
    i       = m_idx;
    lat     = sens_lat[i];
    val     = sens_val[i];
    exp_ack = (lat < int'(TMO));
    exp_req = exp_ack ? lat + 1 : int'(TMO);
    exp_sel = i[SEL_W-1:0];
    alarmClear = rand_clear ? 1'($urandom) : 1'b0;
    gap = 0;
    do begin
      cyc();
      gap++;
    end while (!bus.sampleReq && gap < 40);
    check("req_gap", gap, 1);
    if (!bus.sampleReq) begin
      check("req_seen", bus.sampleReq, 1'b1);
      return;
    end
    if (drop_en) enable = 1'b0;
    nreq   = 0;
    sel_ok = 1'b1;
    while (bus.sampleReq && nreq < 40) begin
      if (bus.sampleSel !== exp_sel) sel_ok = 1'b0;
      if (nreq == lat) begin
        bus.sampleAck  = 1'b1;
        bus.sampleData = val;
      end else begin
        bus.sampleAck  = 1'b0;
        bus.sampleData = 8'($urandom);
      end
      nreq++;
      cyc();
      bus.sampleAck  = 1'b0;
      bus.sampleData = 8'($urandom);
    end
    check("sample_sel", sel_ok, 1'b1);
    check("req_cycles", nreq, exp_req);
    if (exp_ack) begin
      check("analyzer_temp", analyzer_temp, val);
      cyc();
      m_flt[i] = 1'b0;
      if (abn_f(val)) m_cnt[i] = (m_cnt[i] < int'(ALARM)) ? m_cnt[i] + 1 : int'(ALARM);
      else m_cnt[i] = 0;
`ifdef LATCH_ALARM_EN
      if (m_cnt[i] == int'(ALARM)) m_alm[i] = 1'b1;
`else
      m_alm[i] = (m_cnt[i] == int'(ALARM));
`endif
    end else begin
      m_flt[i] = 1'b1;
    end
    check("alarm", alarm, exp_alarm());
    check("sensor_fault", sensor_fault, exp_fault());
    check("scan_done", scan_done, (i == int'(N) - 1));
    m_idx = (i == int'(N) - 1) ? 0 : i + 1;
  endtask

  task automatic round(input bit drop_last);
    for (int k = 0; k < int'(N); k++) visit(drop_last && (k == int'(N) - 1));
  endtask

  task automatic set_all(input int lat, input logic [7:0] val);
    for (int i = 0; i < int'(N); i++) begin
      sens_lat[i] = lat;
      sens_val[i] = val;
    end
  endtask

  initial begin
    int idle_req;
    bus.sampleAck  = 1'b0;
    bus.sampleData = 8'd0;
    model_reset();
    set_all(0, 8'd36);

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_req", bus.sampleReq, 1'b0);
    check("rst_sel", bus.sampleSel, '0);
    check("rst_temp", analyzer_temp, 8'd0);
    check("rst_alarm", alarm, '0);
    check("rst_fault", sensor_fault, '0);
    check("rst_done", scan_done, 1'b0);
    resetN = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    // Normal round, best-case timing.
    round(1'b0);

    // Debounce on sensor 2, then recovery.
    sens_val[2] = 8'd31;
    repeat (3) round(1'b0);
    sens_val[2] = 8'd36;
    round(1'b0);

    // Sensor 1 silent, then answers late.
    sens_lat[1] = NEVER;
    round(1'b0);
    sens_lat[1] = 2;
    round(1'b0);

    // Enable drop during sensor 3, idle, then resume at sensor 0.
    sens_lat[3] = 2;
    round(1'b1);
    idle_req = 0;
    repeat (6) begin
      cyc();
      if (bus.sampleReq) idle_req++;
    end
    check("idle_no_req", idle_req, 0);
    enable = 1'b1;
    round(1'b0);

    // Randomized rounds.
`ifndef LATCH_ALARM_EN
    rand_clear = 1'b1;
`endif
    repeat (10) begin
      for (int i = 0; i < int'(N); i++) begin
        sens_lat[i] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
        sens_val[i] = 8'($urandom_range(30, 40));
      end
      round(1'b0);
    end
    rand_clear = 1'b0;

    // Force alarms on every sensor, then let counts return to zero and stop.
    set_all(0, 8'd31);
    repeat (3) round(1'b0);
    set_all(0, 8'd36);
    round(1'b1);
    alarmClear = 1'b1;
    cyc();
    alarmClear = 1'b0;
`ifdef LATCH_ALARM_EN
    for (int i = 0; i < int'(N); i++) if (m_cnt[i] < int'(ALARM)) m_alm[i] = 1'b0;
`endif
    check("alarm_clear", alarm, exp_alarm());

    // Reset in the middle of a REQ with a fault pending.
    enable = 1'b1;
    sens_lat[0] = NEVER;
    visit(1'b0);
    cyc();
    check("pre_rst_req", bus.sampleReq, 1'b1);
    cyc();
    #2 resetN = 1'b0;
    #1;
    model_reset();
    check("mid_rst_req", bus.sampleReq, 1'b0);
    check("mid_rst_sel", bus.sampleSel, '0);
    check("mid_rst_alarm", alarm, exp_alarm());
    check("mid_rst_fault", sensor_fault, exp_fault());
    check("mid_rst_done", scan_done, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
